// File: rtl/ysyx_22050612_mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter onto the single data-memory port.
// One transaction in flight, round-robin on contention, watchdog abort with sticky err.
module ysyx_22050612_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_addr,
  output logic        if_resp_valid,
  output logic [63:0] if_rdata,
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic [63:0] ls_addr,
  input  logic        ls_wen,
  input  logic [63:0] ls_wdata,
  input  logic [7:0]  ls_wmask,
  output logic        ls_resp_valid,
  output logic [63:0] ls_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_addr,
  output logic        mem_wen,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_rdata,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic        owner, owner_nx;
  logic        last_grant, last_grant_nx;
  logic [15:0] count, count_nx, count_inc;
  logic        err_nx;
  logic        accept;
  logic        grant_ls;
  logic        resp_fire;
  logic [63:0] resp_data;

  assign count_inc = (count == 16'hFFFF) ? count : count + 16'd1;

  // Completion in WAIT is checked before the watchdog so it wins on the boundary cycle.
  always_comb begin
    state_nx      = state;
    owner_nx      = owner;
    last_grant_nx = last_grant;
    count_nx      = count;
    err_nx        = err;
    accept        = 1'b0;
    grant_ls      = 1'b0;
    resp_fire     = 1'b0;
    resp_data     = '0;
    case (state)
      S_IDLE: begin
        if (!rst && (if_req_valid || ls_req_valid)) begin
          accept        = 1'b1;
          grant_ls      = ls_req_valid && (!if_req_valid || !last_grant);
          owner_nx      = grant_ls;
          last_grant_nx = grant_ls;
          count_nx      = '0;
          state_nx      = S_REQ;
        end
      end
      S_REQ: begin
        if (count == LIMIT) begin
          resp_fire = 1'b1;
          err_nx    = 1'b1;
          state_nx  = S_IDLE;
        end else begin
          count_nx = count_inc;
          if (mem_req_ready) begin
            state_nx = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          resp_fire = 1'b1;
          resp_data = mem_rdata;
          state_nx  = S_IDLE;
        end else if (count == LIMIT) begin
          resp_fire = 1'b1;
          err_nx    = 1'b1;
          state_nx  = S_IDLE;
        end else begin
          count_nx = count_inc;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      count      <= '0;
      err        <= 1'b0;
      mem_addr   <= '0;
      mem_wen    <= 1'b0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      last_grant <= last_grant_nx;
      count      <= count_nx;
      err        <= err_nx;
      if (accept) begin
        mem_addr  <= grant_ls ? ls_addr : if_addr;
        mem_wen   <= grant_ls & ls_wen;
        mem_wdata <= grant_ls ? ls_wdata : '0;
        mem_wmask <= grant_ls ? ls_wmask : '0;
      end
    end
  end

  assign if_req_ready  = accept && !grant_ls;
  assign ls_req_ready  = accept && grant_ls;
  assign mem_req_valid = (state == S_REQ);
  assign busy          = (state != S_IDLE);
  assign if_resp_valid = resp_fire && !owner;
  assign ls_resp_valid = resp_fire && owner;
  assign if_rdata      = if_resp_valid ? resp_data : '0;
  assign ls_rdata      = ls_resp_valid ? resp_data : '0;

endmodule

// File: doc/ysyx_22050612_mem_arbiter.md
# ysyx_22050612_mem_arbiter

Two-requester memory port arbiter that shares the single data-memory port between instruction fetch (IFU) and load/store (LSU) in the multi-cycle ysyx_22050612 core. It accepts at most one transaction at a time, grants round-robin on contention, and sequences the request/response phases toward memory. A watchdog ends hung transactions with an error response.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles spent in REQ+WAIT before abort; legal range 1..65535.

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  reset; one clock, reset is asynchronous and active-high
- if_req_valid  in  1  IFU request pending
- if_req_ready  out  1  IFU request accepted this cycle
- if_addr  in  64  IFU fetch address
- if_resp_valid  out  1  IFU response strobe, one cycle
- if_rdata  out  64  IFU read data, 0 when if_resp_valid=0
- ls_req_valid  in  1  LSU request pending
- ls_req_ready  out  1  LSU request accepted this cycle
- ls_addr  in  64  LSU address
- ls_wen  in  1  1 = store, 0 = load
- ls_wdata  in  64  store data
- ls_wmask  in  8  store byte mask
- ls_resp_valid  out  1  LSU response strobe, one cycle
- ls_rdata  out  64  LSU read data, 0 when ls_resp_valid=0
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  64  registered address
- mem_wen  out  1  registered write enable
- mem_wdata  out  64  registered store data
- mem_wmask  out  8  registered mask
- mem_resp_valid  in  1  memory response strobe
- mem_rdata  in  64  memory read data
- busy  out  1  1 whenever state != IDLE
- err  out  1  sticky timeout flag, cleared only by rst

## Operation
- States: IDLE, REQ, WAIT. Registers: state, owner (0=IFU, 1=LSU), last_grant, mem_* request latch, 16-bit watchdog count, err.
- IDLE: if any req_valid, grant one: only one valid -> it; both valid -> the one != last_grant. Assert that requester's req_ready combinationally in that cycle (never both). Latch address/wen/wdata/wmask (IFU: wen=0, wdata=0, wmask=0), set owner, last_grant=owner, count=0 -> REQ.
- REQ: mem_req_valid=1 with latched fields held stable. mem_req_ready=1 -> WAIT.
- WAIT: mem_req_valid=0. mem_resp_valid=1 -> owner's resp_valid=1 and rdata=mem_rdata same cycle (combinational pass-through); -> IDLE. Stores also complete through this response.
- Watchdog: count increments each cycle in REQ or WAIT, saturating at 65535. When count reaches TIMEOUT-1 in a cycle with no completing event: owner resp_valid=1, rdata=0, err<=1, -> IDLE.
- mem_resp_valid in IDLE or REQ: ignored, nothing forwarded, no state change.
- req_ready is 0 in REQ and WAIT; requesters hold valid and fields until ready.
- Non-owner resp_valid always 0; non-owner rdata always 0.

## Timing
- Reset (async assert, sync use after deassert): state=IDLE, owner=0, last_grant=1 (IFU wins first tie), count=0, err=0, mem_addr/wdata/wmask=0, mem_wen=0. All outputs 0.
- Reset mid-transaction: transaction dropped, no response delivered; memory side sees mem_req_valid fall immediately.
- Minimum latency: accept in cycle N, mem_req_valid in N+1, with mem_req_ready at N+1 and mem_resp_valid at N+2 -> resp_valid at N+2; next accept earliest N+3.
- Throughput: one transaction per 3 cycles best case.
- Watchdog boundary: completion (req_ready in REQ is not completion; mem_resp_valid in WAIT is) in the same cycle the count hits TIMEOUT-1 wins over timeout; err unchanged.
- Contention with a held request: loser is granted on the next IDLE cycle if still valid.

## Test plan
- Single IFU fetch, if_addr=0x80000000, memory ready immediately, rdata=0x00100073 next cycle -> if_req_ready at N, mem_req_valid/mem_addr=0x80000000 at N+1, if_resp_valid with if_rdata=0x00100073 at N+2, ls_resp_valid=0 throughout.
- Both request together from reset -> IFU granted first, LSU granted on the following IDLE; third simultaneous pair -> IFU again (alternation).
- LSU store addr=0x80001000, wdata=0x1122334455667788, wmask=0xFF, mem_req_ready delayed 3 cycles -> mem fields stable across 4 REQ cycles, ls_resp_valid exactly one cycle on response.
- TIMEOUT=4, memory never responds -> owner resp_valid with rdata=0 at 4th REQ/WAIT cycle, err=1 and stays 1, busy=0 next cycle.
- Spurious mem_resp_valid in IDLE and in REQ -> no resp_valid on either side, state unchanged.
- rst asserted in WAIT -> busy, mem_req_valid, resp_valid all 0 immediately; after release, fresh LSU request served normally.
